// File: rtl/accel_pkg.sv
// rtl/accel_pkg.sv - shared types and constants for the accelerator command sequencer
//
// Purpose: FSM state encoding, register address map, CTRL/STATUS/PMOD bit
// indices and the CHAIN flag position inside the OPCODE register.
// Ports: none (package).

package accel_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } seq_state_e;

  localparam logic [3:0] ADDR_CTRL     = 4'h0;
  localparam logic [3:0] ADDR_OPCODE   = 4'h1;
  localparam logic [3:0] ADDR_OPA      = 4'h2;
  localparam logic [3:0] ADDR_OPB      = 4'h3;
  localparam logic [3:0] ADDR_RESULT   = 4'h4;
  localparam logic [3:0] ADDR_LEN      = 4'h5;
  localparam logic [3:0] ADDR_DONE_CNT = 4'h6;
  localparam logic [3:0] ADDR_PERF_LO  = 4'h7;
  localparam logic [3:0] ADDR_PERF_HI  = 4'h8;

  // CTRL write bits
  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;
  localparam int CTRL_CLEAR = 2;

  // STATUS read bits
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_ERROR   = 2;
  localparam int STAT_ABORTED = 3;

  // PMOD (uo_out) bits; bit0 stays reserved for the UART
  localparam int UO_BUSY  = 1;
  localparam int UO_DONE  = 2;
  localparam int UO_ERROR = 3;

  // OPCODE register bit selecting result->operand A chaining
  localparam int OPCODE_CHAIN = 7;

endpackage

// File: rtl/accel_cmd_sequencer_if.sv
// rtl/accel_cmd_sequencer_if.sv - register bus and datapath handshake bundle
//
// Purpose: groups the TinyQV register bus, the PMOD output and the datapath
// request/result handshake of the command sequencer.
// Modports:
//   slave  - the sequencer (register-bus slave; drives data_out, uo_out and
//            the op_* request, receives op_ready/res_valid/res_data)
//   master - the environment (CPU bus plus datapath)
// Signals: address[3:0], data_write, data_in[7:0], data_out[7:0], uo_out[7:0],
//   op_valid, op_ready, op_code[7:0], op_a/op_b[DATA_W], res_valid,
//   res_data[DATA_W].

interface accel_cmd_sequencer_if #(
  parameter int DATA_W = 8
);
  logic [3:0]        address;
  logic              data_write;
  logic [7:0]        data_in;
  logic [7:0]        data_out;
  logic [7:0]        uo_out;
  logic              op_valid;
  logic              op_ready;
  logic [7:0]        op_code;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              res_valid;
  logic [DATA_W-1:0] res_data;

  modport slave (
    input  address, data_write, data_in, op_ready, res_valid, res_data,
    output data_out, uo_out, op_valid, op_code, op_a, op_b
  );

  modport master (
    output address, data_write, data_in, op_ready, res_valid, res_data,
    input  data_out, uo_out, op_valid, op_code, op_a, op_b
  );
endinterface

// File: rtl/accel_seq_timeout.sv
// rtl/accel_seq_timeout.sv - loadable down-counter with last-cycle flag
//
// Purpose: counts down the cycles a request may wait for its result.
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_load         load i_load_val (has priority over counting)
//   i_load_val     number of cycles allowed
//   i_en           count down this cycle
//   o_last         the current cycle is the final permitted one

module accel_seq_timeout #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_last
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  // A load of N yields exactly N enabled cycles, the last of which flags.
  assign o_last = (r_count == W'(1));

endmodule

// File: rtl/accel_cmd_sequencer.sv
// rtl/accel_cmd_sequencer.sv - command sequencer between TinyQV bus and accelerator datapath
//
// Purpose: byte register file (opcode, operands, length, result, completion
// count, status) plus an FSM that issues LEN requests to the datapath,
// optionally chaining each result into operand A.
// Ports:
//   clk   clock
//   rst   asynchronous active-high reset
//   bus   accel_cmd_sequencer_if.slave: register bus (address, data_write,
//         data_in, data_out), PMOD uo_out, datapath op_valid/op_ready/op_code/
//         op_a/op_b and res_valid/res_data
// Optional build macro: ACCEL_SEQ_PERF_EN adds a 16-bit busy-cycle counter
// readable at PERF_LO/PERF_HI; without it those addresses read 0.

module accel_cmd_sequencer
  import accel_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  accel_cmd_sequencer_if.slave  bus
);

  seq_state_e        r_state;
  seq_state_e        w_state_next;

  logic [7:0]        r_opcode;
  logic [DATA_W-1:0] r_opa;
  logic [DATA_W-1:0] r_opb;
  logic [DATA_W-1:0] r_result;
  logic [CNT_W-1:0]  r_len;
  logic [CNT_W-1:0]  r_done_cnt;
  logic              r_done;
  logic              r_error;
  logic              r_aborted;

  logic              w_busy;
  logic              w_wr_ctrl;
  logic              w_start;
  logic              w_abort;
  logic              w_clear;
  logic              w_cfg_wr;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              w_last_iter;
  logic              w_tmo_last;

  logic              w_capture;
  logic              w_accept_start;
  logic              w_set_done;
  logic              w_set_error;
  logic              w_set_aborted;
  logic              w_tmo_load;

  logic [7:0]        w_status;
  logic [7:0]        w_uo;
  logic [7:0]        w_rd_data;
  logic [7:0]        w_perf_lo;
  logic [7:0]        w_perf_hi;

  assign w_busy    = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
  assign w_wr_ctrl = bus.data_write && (bus.address == ADDR_CTRL);
  // ABORT in the same write suppresses START.
  assign w_start   = w_wr_ctrl && bus.data_in[CTRL_START] && !bus.data_in[CTRL_ABORT];
  assign w_abort   = w_wr_ctrl && bus.data_in[CTRL_ABORT];
  assign w_clear   = w_wr_ctrl && bus.data_in[CTRL_CLEAR];
  // Configuration is frozen for the duration of a run.
  assign w_cfg_wr  = bus.data_write && !w_busy;

  assign w_cnt_inc   = r_done_cnt + CNT_W'(1);
  assign w_last_iter = (w_cnt_inc == r_len);

  accel_seq_timeout #(
    .W (16)
  ) u_timeout (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_load     (w_tmo_load),
    .i_load_val (16'(TIMEOUT)),
    .i_en       (r_state == ST_WAIT),
    .o_last     (w_tmo_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_capture      = 1'b0;
    w_accept_start = 1'b0;
    w_set_done     = 1'b0;
    w_set_error    = 1'b0;
    w_set_aborted  = 1'b0;
    w_tmo_load     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_accept_start = 1'b1;
          if (r_len != '0) begin
            w_state_next = ST_ISSUE;
          end else begin
            w_state_next = ST_DONE;
            w_set_done   = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (w_abort) begin
          w_state_next  = ST_IDLE;
          w_set_aborted = 1'b1;
        end else if (bus.op_ready) begin
          if (bus.res_valid) begin
            // Zero-latency datapath: the result arrives with the accept.
            w_capture = 1'b1;
            if (w_last_iter) begin
              w_state_next = ST_DONE;
              w_set_done   = 1'b1;
            end else begin
              w_state_next = ST_ISSUE;
            end
          end else begin
            w_state_next = ST_WAIT;
            w_tmo_load   = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (w_abort) begin
          w_state_next  = ST_IDLE;
          w_set_aborted = 1'b1;
        end else if (bus.res_valid) begin
          w_capture = 1'b1;
          if (w_last_iter) begin
            w_state_next = ST_DONE;
            w_set_done   = 1'b1;
          end else begin
            w_state_next = ST_ISSUE;
          end
        end else if (w_tmo_last) begin
          w_state_next = ST_ERROR;
          w_set_error  = 1'b1;
        end
      end
      ST_DONE:  w_state_next = ST_IDLE;
      ST_ERROR: w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_opcode   <= '0;
      r_opa      <= '0;
      r_opb      <= '0;
      r_result   <= '0;
      r_len      <= '0;
      r_done_cnt <= '0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_aborted  <= 1'b0;
    end else begin
      if (w_cfg_wr) begin
        case (bus.address)
          ADDR_OPCODE: r_opcode <= bus.data_in;
          ADDR_OPA:    r_opa    <= DATA_W'(bus.data_in);
          ADDR_OPB:    r_opb    <= DATA_W'(bus.data_in);
          ADDR_LEN:    r_len    <= CNT_W'(bus.data_in);
          default:     ;
        endcase
      end
      // Captures only happen while busy, so they never collide with the
      // configuration writes above.
      if (w_capture) begin
        r_result   <= bus.res_data;
        r_done_cnt <= w_cnt_inc;
        if (r_opcode[OPCODE_CHAIN]) begin
          r_opa <= bus.res_data;
        end
      end
      if (w_accept_start) begin
        r_done_cnt <= '0;
      end
      if (w_clear || w_accept_start) begin
        r_done    <= 1'b0;
        r_error   <= 1'b0;
        r_aborted <= 1'b0;
      end
      if (w_set_done) begin
        r_done <= 1'b1;
      end
      if (w_set_error) begin
        r_error <= 1'b1;
      end
      if (w_set_aborted) begin
        r_aborted <= 1'b1;
      end
    end
  end

`ifdef ACCEL_SEQ_PERF_EN
  logic [15:0] r_perf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf <= '0;
    end else if (w_accept_start) begin
      r_perf <= '0;
    end else if (w_busy) begin
      r_perf <= r_perf + 16'd1;
    end
  end

  assign w_perf_lo = r_perf[7:0];
  assign w_perf_hi = r_perf[15:8];
`else
  assign w_perf_lo = 8'h00;
  assign w_perf_hi = 8'h00;
`endif

  always_comb begin
    w_status               = '0;
    w_status[STAT_BUSY]    = w_busy;
    w_status[STAT_DONE]    = r_done;
    w_status[STAT_ERROR]   = r_error;
    w_status[STAT_ABORTED] = r_aborted;
    w_uo                   = '0;
    w_uo[UO_BUSY]          = w_busy;
    w_uo[UO_DONE]          = r_done;
    w_uo[UO_ERROR]         = r_error;
  end

  always_comb begin
    w_rd_data = 8'h00;
    case (bus.address)
      ADDR_CTRL:     w_rd_data = w_status;
      ADDR_OPCODE:   w_rd_data = r_opcode;
      ADDR_OPA:      w_rd_data = 8'(r_opa);
      ADDR_OPB:      w_rd_data = 8'(r_opb);
      ADDR_RESULT:   w_rd_data = 8'(r_result);
      ADDR_LEN:      w_rd_data = 8'(r_len);
      ADDR_DONE_CNT: w_rd_data = 8'(r_done_cnt);
      ADDR_PERF_LO:  w_rd_data = w_perf_lo;
      ADDR_PERF_HI:  w_rd_data = w_perf_hi;
      default:       w_rd_data = 8'h00;
    endcase
  end

  assign bus.data_out = w_rd_data;
  assign bus.uo_out   = w_uo;
  assign bus.op_valid = (r_state == ST_ISSUE);
  assign bus.op_code  = {1'b0, r_opcode[6:0]};
  assign bus.op_a     = r_opa;
  assign bus.op_b     = r_opb;

endmodule

// File: doc/accel_cmd_sequencer.md
Name: accel_cmd_sequencer

Overview:
Command sequencer between the TinyQV peripheral register bus and the configurable accelerator datapath. Software programs opcode, operands and iteration count through byte registers, then writes START. The block issues LEN operations to the datapath over a valid/ready request plus result-valid handshake, optionally chaining each result into operand A. It reports busy/done/error/abort status on the bus and on the PMOD.

Parameters:
DATA_W, 8, operand/result width (bus registers are 8 bits; values wider than 8 are zero-extended on write and truncated on read)
CNT_W, 8, width of LEN and iteration counters
TIMEOUT, 255, max cycles in WAIT before error (range 1..2^16-1)

Ports:
clk  in  1  clock, single domain
rst  in  1  reset, asynchronous, active-high
address  in  4  register address
data_write  in  1  write strobe, data_in valid
data_in  in  8  write data
data_out  out  8  read data, combinational from address
uo_out  out  8  [0]=0 (UART reserved), [1]=busy, [2]=done, [3]=error, [7:4]=0
op_valid  out  1  request to datapath
op_ready  in  1  datapath accepts request
op_code  out  8  opcode[6:0], bit7 forced 0
op_a  out  DATA_W  operand A
op_b  out  DATA_W  operand B
res_valid  in  1  datapath result strobe
res_data  in  DATA_W  datapath result

Behaviour:
- Register map, written only when data_write=1:
  - 0x0 CTRL write: bit0 START, bit1 ABORT, bit2 CLEAR (clears done/error/aborted). Read: STATUS {4'b0, aborted, error, done, busy}.
  - 0x1 OPCODE: bit7 = CHAIN.
  - 0x2 OPA.
  - 0x3 OPB.
  - 0x4 RESULT, read-only: last captured res_data.
  - 0x5 LEN.
  - 0x6 DONE_CNT, read-only: completed iterations.
  - Unmapped addresses read 0.
- Writes to 0x1/0x2/0x3/0x5 while busy are ignored.
- Reset (async assert): all registers 0, state IDLE, op_valid=0, uo_out=0, data_out reflects zeroed registers.
- FSM states: IDLE, ISSUE, WAIT, DONE, ERROR. busy=1 in ISSUE and WAIT.
- IDLE:
  - START with LEN!=0 -> ISSUE next cycle; DONE_CNT<=0; done/error/aborted cleared.
  - START with LEN=0 -> DONE; no op issued.
- ISSUE:
  - op_valid=1; op_code/op_a/op_b held stable until op_ready=1.
  - On op_ready -> WAIT.
  - If res_valid is also high in that same cycle, treat it as result capture (zero-latency datapath) and skip WAIT.
- WAIT:
  - Timeout counter increments each cycle.
  - On res_valid: RESULT<=res_data, DONE_CNT++, timeout counter<=0. If CHAIN, OPA<=res_data.
  - If DONE_CNT+1==LEN -> DONE, else -> ISSUE.
  - Counter reaching TIMEOUT without res_valid -> ERROR.
- res_valid outside ISSUE/WAIT is ignored.
- DONE: done=1, then -> IDLE the same cycle (done is a sticky flag). ERROR: error=1, then -> IDLE.
- ABORT in ISSUE/WAIT: -> IDLE next cycle, op_valid drops, aborted=1, RESULT/DONE_CNT keep their current values. ABORT in IDLE has no effect.
- Simultaneous writes:
  - START+ABORT in the same write: ABORT wins.
  - CLEAR+START: START takes effect with flags cleared.
  - START while busy: ignored.
- Counters do not wrap within a run: LEN <= 2^CNT_W-1.
- Latency: START write at cycle n -> op_valid=1 at n+1.

Optional Feature:
- Macro ACCEL_SEQ_PERF_EN.
- Defined: 16-bit cycle counter cleared on accepted START, increments every busy cycle, frozen otherwise. Low byte reads at 0x7, high byte at 0x8.
- Undefined: 0x7/0x8 read 0 and no counter logic exists.

Decomposition:
- Shared package accel_pkg holds:
  - FSM state enum
  - register address constants (ADDR_CTRL .. ADDR_PERF_HI)
  - CTRL/STATUS bit indices
- Sub-module accel_seq_timeout: loadable down-counter with expiry flag, reused by the WAIT timeout.
- Register file and FSM live in the top module.

Test Plan:
- Single op: OPCODE=0x03, OPA=5, OPB=7, LEN=1, START. Datapath holds op_ready high and returns 12 two cycles later. Expect RESULT=12, DONE_CNT=1, STATUS=0x02, uo_out=0x04.
- Chain: CHAIN=1, OPA=1, LEN=4, model returns op_a+1. Expect op_a sequence 1,2,3,4, then RESULT=5, DONE_CNT=4.
- Backpressure: op_ready low for 10 cycles. Expect op_valid held and operands stable throughout; exactly one transfer when op_ready rises.
- Timeout: TIMEOUT=16, never assert res_valid. Expect STATUS.error=1 with busy=0 at 16 cycles after op acceptance; CLEAR then returns STATUS=0.
- Abort/reset mid-run:
  - ABORT during WAIT of iteration 2 of 3: expect aborted=1, DONE_CNT=1, op_valid=0 next cycle.
  - Assert rst asynchronously mid-ISSUE: expect op_valid=0 immediately and all registers 0.
- Edge cases:
  - LEN=0 START: done=1 with no op_valid pulse.
  - Write OPB while busy: OPB unchanged.
  - With ACCEL_SEQ_PERF_EN: 0x7 equals the busy-cycle count.
